stream_rr_arbiter: RTL and testbench



---
 rtl/stream_rr_arbiter_pkg.sv | 18 +
 rtl/stream_rr_arbiter_grant_pick.sv | 35 +++
 rtl/stream_rr_arbiter.sv | 108 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter.
// State encoding and the source-index width function live here.
package stream_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Index width for n requesters; never below one bit so a single port still has a src field.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_grant_pick.sv
// Combinational rotating-priority picker: first set request strictly after ptr,
// wrapping modulo NumPorts.
module rr_grant_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NumPorts = 4,
    parameter int SrcBits  = clog2_min1(NumPorts)
) (
    input  logic [NumPorts-1:0] req,
    input  logic [SrcBits-1:0]  ptr,
    output logic                gnt_valid,
    output logic [SrcBits-1:0]  gnt_idx
);

    logic [2*NumPorts-1:0] w_dbl;
    logic [NumPorts-1:0]   w_rot;
    int                    w_off;
    int                    w_sum;

    // Doubling the vector turns the wrap-around scan into a plain shift.
    assign w_dbl = {req, req};
    assign w_rot = NumPorts'(w_dbl >> (int'(ptr) + 1));

    always_comb begin
        w_off = 0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = k;
        end
        w_sum = int'(ptr) + 1 + w_off;
        if (w_sum >= NumPorts) w_sum = w_sum - NumPorts;
        gnt_idx   = SrcBits'(w_sum);
        gnt_valid = |w_rot;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 packet-aware round-robin arbiter with a registered single-entry output stage.
// A port keeps the grant from its first beat through the beat carrying last.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter  int NumPorts = 4,
    parameter  int Width    = 8,
    localparam int SrcBits  = clog2_min1(NumPorts)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NumPorts-1:0]       in_valid,
    output logic [NumPorts-1:0]       in_ready,
    input  logic [NumPorts*Width-1:0] in_data,
    input  logic [NumPorts-1:0]       in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Width-1:0]          out_data,
    output logic                      out_last,
    output logic [SrcBits-1:0]        out_src,
    output logic                      locked
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SrcBits-1:0]  r_owner;
    logic [SrcBits-1:0]  r_prio_ptr;
    logic                w_gnt_valid;
    logic [SrcBits-1:0]  w_gnt_idx;
    logic [SrcBits-1:0]  w_sel;
    logic [Width-1:0]    w_sel_data;
    logic                w_sel_last;
    logic                w_ld;
    logic                w_acc;
    logic [NumPorts-1:0] w_ready;
    logic                r_out_valid;
    logic [Width-1:0]    r_out_data;
    logic                r_out_last;
    logic [SrcBits-1:0]  r_out_src;

    rr_grant_pick #(
        .NumPorts (NumPorts),
        .SrcBits  (SrcBits)
    ) u_pick (
        .req       (in_valid),
        .ptr       (r_prio_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign w_ld       = ~r_out_valid | out_ready;
    assign w_sel      = (r_state == ST_LOCKED) ? r_owner : w_gnt_idx;
    assign w_sel_data = in_data[w_sel*Width +: Width];
    assign w_sel_last = in_last[w_sel];
    assign w_acc      = |(in_valid & w_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) w_state_nxt = w_sel_last ? ST_IDLE : ST_LOCKED;
    end

    always_comb begin
        w_ready = '0;
        if (r_state == ST_LOCKED || w_gnt_valid) w_ready[w_sel] = w_ld;
    end

    assign in_ready = w_ready;
    assign locked   = (r_state == ST_LOCKED);

    // Pointer follows every accepted beat, so after a packet the scan resumes at owner+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= '0;
            r_prio_ptr <= SrcBits'(NumPorts - 1);
        end else if (w_acc) begin
            r_owner    <= w_sel;
            r_prio_ptr <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_src   <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (4 ports x 8 bits): per-port beat queues
// feed the inputs, accepted output beats are logged and compared to hand-worked sequences.
module tb_stream_rr_arbiter;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int SB = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_ready;
    logic [NP*W-1:0] in_data;
    logic [NP-1:0]   in_last;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [SB-1:0]   out_src;
    logic            locked;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NumPorts(NP), .Width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .locked    (locked)
    );

    logic [8:0]    mem [NP][64];
    int            hd [NP];
    int            tl [NP];
    logic [NP-1:0] hold;
    logic          ordy;
    int            n_chk;
    int            n_pass;
    int            cyc;

    logic [W-1:0]  ob_data [128];
    logic [SB-1:0] ob_src  [128];
    logic          ob_last [128];
    int            ob_cyc  [128];
    int            n_out;

    logic [NP-1:0] s_in_ready;
    logic          s_out_valid;
    logic [W-1:0]  s_out_data;
    logic          s_locked;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input int p, input logic last, input logic [7:0] d);
        mem[p][tl[p]] = {last, d};
        tl[p]++;
    endtask

    // One clock: drive queue heads at negedge, sample handshakes just before posedge.
    task automatic step();
        logic [NP-1:0] fire;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            in_valid[i]       = (hd[i] != tl[i]) && !hold[i];
            in_last[i]        = mem[i][hd[i]][8];
            in_data[i*W +: W] = mem[i][hd[i]][7:0];
        end
        out_ready = ordy;
        #4;
        fire        = in_valid & in_ready;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_locked    = locked;
        if (out_valid && out_ready && n_out < 128) begin
            ob_data[n_out] = out_data;
            ob_src[n_out]  = out_src;
            ob_last[n_out] = out_last;
            ob_cyc[n_out]  = cyc;
            n_out++;
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NP; i++) if (fire[i]) hd[i]++;
    endtask

    task automatic check_beat(input string tag, input int k, input logic [7:0] d, input int src);
        check({tag, "_data"}, ob_data[k], d);
        check({tag, "_src"}, ob_src[k], src);
    endtask

    initial begin
        int lk;
        n_chk = 0; n_pass = 0; cyc = 0; n_out = 0;
        hold = '0; ordy = 1'b0;
        for (int i = 0; i < NP; i++) begin
            hd[i] = 0; tl[i] = 0;
            for (int j = 0; j < 64; j++) mem[i][j] = '0;
        end
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_src", out_src, 0);
        check("rst_locked", locked, 0);
        in_valid = 4'hF;
        #1;
        check("rst_prio_port0", in_ready, 4'b0001);
        in_valid = '0;
        #1;
        rst_n = 1'b1;

        // T1: one single-beat packet per port, back to back
        ordy = 1'b1;
        for (int i = 0; i < NP; i++) push(i, 1'b1, 8'(8'h10 + i));
        repeat (6) step();
        check("t1_count", n_out, 4);
        for (int k = 0; k < 4; k++) begin
            check_beat("t1", k, 8'(8'h10 + k), k);
            check("t1_gap", ob_cyc[k] - ob_cyc[0], k);
        end

        // T2: 3-beat packet from port 2 while port 1 waits
        push(1, 1'b1, 8'h50);
        repeat (3) step();
        n_out = 0; lk = 0;
        push(2, 1'b0, 8'hA0); push(2, 1'b0, 8'hA1); push(2, 1'b1, 8'hA2);
        push(1, 1'b1, 8'h51);
        for (int k = 0; k < 7; k++) begin
            step();
            if (s_locked) lk++;
        end
        check("t2_count", n_out, 4);
        check_beat("t2_b0", 0, 8'hA0, 2);
        check_beat("t2_b1", 1, 8'hA1, 2);
        check_beat("t2_b2", 2, 8'hA2, 2);
        check_beat("t2_b3", 3, 8'h51, 1);
        check("t2_last", ob_last[2], 1);
        check("t2_gap", ob_cyc[3] - ob_cyc[0], 3);
        check("t2_locked_cycles", lk, 2);

        // T3: downstream stall mid-packet
        n_out = 0;
        push(3, 1'b0, 8'hC0); push(3, 1'b0, 8'hC1); push(3, 1'b1, 8'hC2);
        step(); step();
        ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_stall_valid", s_out_valid, 1);
            check("t3_stall_data", s_out_data, 8'hC1);
            check("t3_stall_ready", s_in_ready, 0);
        end
        ordy = 1'b1;
        repeat (4) step();
        check("t3_count", n_out, 3);
        check_beat("t3_b0", 0, 8'hC0, 3);
        check_beat("t3_b1", 1, 8'hC1, 3);
        check_beat("t3_b2", 2, 8'hC2, 3);

        // T4: owner port 3 goes quiet mid-packet; port 0 must stay blocked
        n_out = 0;
        push(3, 1'b0, 8'hD0); push(3, 1'b0, 8'hD1); push(3, 1'b1, 8'hD2);
        step();
        hold[3] = 1'b1;
        push(0, 1'b1, 8'h77);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_port0_blocked", s_in_ready[0], 0);
            check("t4_locked", s_locked, 1);
        end
        hold[3] = 1'b0;
        repeat (6) step();
        check("t4_count", n_out, 4);
        check_beat("t4_b0", 0, 8'hD0, 3);
        check_beat("t4_b1", 1, 8'hD1, 3);
        check_beat("t4_b2", 2, 8'hD2, 3);
        check_beat("t4_b3", 3, 8'h77, 0);

        // T5: fairness, park pointer on port 3 then all ports stream single beats
        push(3, 1'b1, 8'hEE);
        repeat (3) step();
        n_out = 0;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < NP; i++) push(i, 1'b1, 8'(i * 16 + k));
        repeat (44) step();
        check("t5_count", n_out, 40);
        for (int k = 0; k < 40; k++)
            check_beat("t5", k, 8'((k % 4) * 16 + k / 4), k % 4);
        check("t5_gap", ob_cyc[39] - ob_cyc[0], 39);

        // T6: asynchronous reset in the middle of a packet
        n_out = 0;
        push(1, 1'b0, 8'hE0); push(1, 1'b0, 8'hE1); push(1, 1'b1, 8'hE2);
        step(); step();
        check("t6_pre_locked", locked, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_locked", locked, 0);
        for (int i = 0; i < NP; i++) hd[i] = tl[i];
        #1;
        rst_n = 1'b1;
        n_out = 0;
        push(2, 1'b1, 8'h62);
        push(0, 1'b1, 8'h60);
        repeat (4) step();
        check("t6_count", n_out, 2);
        check_beat("t6_b0", 0, 8'h60, 0);
        check_beat("t6_b1", 1, 8'h62, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
